// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/onehot_enc_4_2.sv
// One-hot to binary encoder for a 4-bit grant vector; all-zero input encodes to 0.
// Latency: combinational.
// Backpressure: none.
module onehot_enc_4_2
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    assign idx = {onehot[3] | onehot[2], onehot[3] | onehot[1]};

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant locking; optional owner timeout via ARB_TIMEOUT_EN.
// Latency: req to gnt one edge; handover on owner release one edge, no idle gap.
// Backpressure: owner keeps the grant while its req is high; other requesters wait for handover.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_check
        $error("HOLD_MAX must be within 2..255");
    end

    state_t             state_q, state_nxt;
    logic [IDX_W-1:0]   ptr_q, ptr_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt, enc_idx;
    logic               vld_q;

    logic               owner_req, hold_expired, release_grant;
    logic               new_grant, regrant;
    logic [IDX_W-1:0]   scan_base, cand_pos, winner;
    logic [NUM_REQ-1:0] cand;
    logic               win_found;

    assign owner_req     = req[idx_q];
    assign release_grant = (state_q == ST_BUSY) && (!owner_req || hold_expired);

    // In BUSY the scan starts after the owner and excludes it; in IDLE it starts at ptr.
    assign scan_base = (state_q == ST_BUSY) ? idx_q + 2'd1 : ptr_q;
    assign cand      = (state_q == ST_BUSY) ? (req & ~gnt_q) : req;

    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        cand_pos  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_pos = scan_base + IDX_W'(i);
            if (cand[cand_pos]) begin
                win_found = 1'b1;
                winner    = cand_pos;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt_q;

    // Expires during the HOLD_MAX-th cycle of ownership.
    assign hold_expired = (state_q == ST_BUSY) && (hold_cnt_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else if (new_grant || regrant || state_nxt == ST_IDLE) begin
            hold_cnt_q <= '0;
        end else if (state_q == ST_BUSY) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ptr_q   <= ptr_nxt;
            gnt_q   <= gnt_nxt;
            idx_q   <= idx_nxt;
            vld_q   <= |gnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        new_grant = 1'b0;
        regrant   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (win_found) begin
                state_nxt = ST_BUSY;
                new_grant = 1'b1;
            end
        end else if (release_grant) begin
            if (win_found) begin
                new_grant = 1'b1;
            end else if (owner_req) begin
                // Timed out with nobody else waiting: the owner keeps going.
                regrant = 1'b1;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        gnt_nxt = gnt_q;
        ptr_nxt = ptr_q;
        if (new_grant) begin
            gnt_nxt = idx_to_onehot(winner);
            ptr_nxt = winner + 2'd1;
        end else if (regrant) begin
            ptr_nxt = idx_q + 2'd1;
        end else if (state_nxt == ST_IDLE) begin
            gnt_nxt = '0;
        end
    end

    onehot_enc_4_2 u_enc (
        .onehot (gnt_nxt),
        .idx    (enc_idx)
    );

    assign idx_nxt   = (|gnt_nxt) ? enc_idx : idx_q;

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: expectations queued at drive time, checked after each edge.
// Latency: n/a.
// Backpressure: n/a.
module tb_rr_arbiter_4;
    import arb_pkg::*;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: got %0d entries, expected at least 1", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (gnt === e.gnt) else begin
                errors++;
                $error("FAIL %s gnt: got %b expected %b", e.tag, gnt, e.gnt);
            end
            checks++;
            assert (gnt_idx === e.idx) else begin
                errors++;
                $error("FAIL %s gnt_idx: got %b expected %b", e.tag, gnt_idx, e.idx);
            end
            checks++;
            assert (gnt_valid === e.vld) else begin
                errors++;
                $error("FAIL %s gnt_valid: got %b expected %b", e.tag, gnt_valid, e.vld);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the state expected after the next edge, then check it.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [1:0] ei, input string tag);
        exp_t e;
        @(negedge clk);
        rst   = r;
        req   = rq;
        e.gnt = eg;
        e.idx = ei;
        e.vld = |eg;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset wins over request activity.
        step(1'b1, 4'b1111, 4'b0000, 2'd0, "reset0");
        step(1'b1, 4'b1111, 4'b0000, 2'd0, "reset1");

        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b0000, 2'd0, "idle");

        step(1'b0, 4'b0100, 4'b0100, 2'd2, "single_grant");
        step(1'b0, 4'b0000, 4'b0000, 2'd2, "single_release");

        // ptr is now 3: scan wraps to 0, then hands over to 1.
        step(1'b0, 4'b0011, 4'b0001, 2'd0, "wrap_grant0");
        step(1'b0, 4'b0010, 4'b0010, 2'd1, "wrap_handover1");
        step(1'b0, 4'b0000, 4'b0000, 2'd1, "wrap_release");

        step(1'b1, 4'b0000, 4'b0000, 2'd0, "reset_ptr");

        step(1'b0, 4'b1111, 4'b0001, 2'd0, "rr_g0a");
        step(1'b0, 4'b1111, 4'b0001, 2'd0, "rr_g0b");
        step(1'b0, 4'b1110, 4'b0010, 2'd1, "rr_g1a");
        step(1'b0, 4'b1111, 4'b0010, 2'd1, "rr_g1b");
        step(1'b0, 4'b1101, 4'b0100, 2'd2, "rr_g2a");
        step(1'b0, 4'b1111, 4'b0100, 2'd2, "rr_g2b");
        step(1'b0, 4'b1011, 4'b1000, 2'd3, "rr_g3a");
        step(1'b0, 4'b1111, 4'b1000, 2'd3, "rr_g3b");
        step(1'b0, 4'b0111, 4'b0001, 2'd0, "rr_g0_wrap");
        step(1'b0, 4'b1111, 4'b0001, 2'd0, "rr_g0_hold");

        step(1'b0, 4'b0000, 4'b0000, 2'd0, "mid_idle");
        step(1'b0, 4'b1000, 4'b1000, 2'd3, "mid_grant3");
        step(1'b0, 4'b1000, 4'b1000, 2'd3, "mid_hold3");
        step(1'b1, 4'b1000, 4'b0000, 2'd0, "mid_reset");
        step(1'b0, 4'b1000, 4'b1000, 2'd3, "mid_regrant3");
        step(1'b0, 4'b0000, 4'b0000, 2'd3, "mid_release");

`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 12; k++) begin
            if (((k / 4) % 2) == 0) step(1'b0, 4'b0011, 4'b0001, 2'd0, "tmo_alt_g0");
            else                    step(1'b0, 4'b0011, 4'b0010, 2'd1, "tmo_alt_g1");
        end
        for (int k = 0; k < 10; k++) step(1'b0, 4'b0001, 4'b0001, 2'd0, "tmo_solo");
`else
        for (int k = 0; k < 20; k++) step(1'b0, 4'b0011, 4'b0001, 2'd0, "lock_g0");
        for (int k = 0; k < 4; k++)  step(1'b0, 4'b0001, 4'b0001, 2'd0, "lock_solo");
`endif
        step(1'b0, 4'b0010, 4'b0010, 2'd1, "final_handover");
        step(1'b0, 4'b0000, 4'b0000, 2'd1, "final_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
